// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive framing controller.
//
// Synchronises the asynchronous rx line, detects a start bit, samples
// DATA_BITS data bits (LSB first) and a stop bit on center_tick pulses from an
// external phase counter. It presents the byte on a valid/ready handshake and
// keeps sticky frame-error and overrun flags.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   rx           asynchronous serial line, idle high
//   rx_en        receiver enable; low aborts any frame in progress
//   center_tick  one-cycle pulse at the bit centre from the phase counter
//   phase_arm    holds the phase counter at zero while high
//   rx_data      last received byte
//   rx_valid     rx_data holds an unaccepted byte
//   rx_ready     consumer accepts the byte when rx_valid & rx_ready
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: a byte arrived before the previous one was accepted
//   err_clr      one-cycle pulse that clears frame_err and overrun
//   busy         high whenever the receiver is not idle
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_en,
  input  logic                 center_tick,
  output logic                 phase_arm,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBrk
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [CntW-1:0]        bit_cnt_q;

  logic rx_s;
  logic load;
  logic ferr_evt;
  logic accept;
  logic ovr_evt;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    load     = rx_en && (state_q == StStop) && center_tick && rx_s;
    ferr_evt = rx_en && (state_q == StStop) && center_tick && !rx_s;
    accept   = rx_valid && rx_ready;
    // A load in the same cycle as an accept replaces the byte cleanly.
    ovr_evt  = load && rx_valid && !rx_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      phase_arm <= 1'b1;
      busy      <= 1'b0;
      sync_q    <= '1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};

      // Output handshake; a new load takes priority over the accept clear.
      if (load) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end

      // Error events win over a simultaneous clear.
      if (ferr_evt) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end

      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end

      if (!rx_en) begin
        // Drop the partial frame; delivered data and flags are left alone.
        state_q   <= StIdle;
        phase_arm <= 1'b1;
        busy      <= 1'b0;
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q   <= StStart;
              phase_arm <= 1'b0;
              busy      <= 1'b1;
            end
          end
          StStart: begin
            if (center_tick) begin
              if (rx_s) begin
                // Line went back high before the start-bit centre: glitch.
                state_q   <= StIdle;
                phase_arm <= 1'b1;
                busy      <= 1'b0;
              end else begin
                state_q   <= StData;
                bit_cnt_q <= '0;
              end
            end
          end
          StData: begin
            if (center_tick) begin
              shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              if (bit_cnt_q == CntW'(DATA_BITS - 1)) begin
                state_q <= StStop;
              end
            end
          end
          StStop: begin
            if (center_tick) begin
              state_q   <= rx_s ? StIdle : StBrk;
              phase_arm <= 1'b1;
              busy      <= !rx_s;
            end
          end
          StBrk: begin
            // Wait out a break/low line so it is not taken as a new start bit.
            if (rx_s) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
          default: begin
            state_q   <= StIdle;
            phase_arm <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: 16x phase counter model, directed
// frames, and a scoreboard queue of expected bytes popped on each handshake.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_en = 1'b0;
  logic       rx_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic       center_tick;
  logic       phase_arm;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic [3:0] pc;
  int         tests = 0;
  int         fails = 0;
  int         valid_cycles = 0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_en      (rx_en),
    .center_tick(center_tick),
    .phase_arm  (phase_arm),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Phase counter, OVERSAMPLE=16, baud enable every cycle; centre at count 7.
  always @(posedge clk) begin
    if (!rst_n || phase_arm) pc <= 4'd0;
    else                     pc <= pc + 4'd1;
  end
  assign center_tick = !phase_arm && (pc == 4'd7);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sample 1ns after the falling edge, pop on every accepted byte.
  always begin : monitor
    logic [7:0] e;
    @(negedge clk);
    #1;
    if (rst_n && rx_valid) valid_cycles++;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", 32'(rx_data), 32'(e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    check("busy_before_stop", 32'(busy), 32'd1);
    rx = stop_val;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_phase_arm"}, 32'(phase_arm), 32'd1);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] d6b;
    d6b = 8'h6B;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    rx_en = 1'b1;
    idle(20);

    // Clean 0xA5 frame, consumer always ready.
    exp_q.push_back(8'hA5);
    valid_cycles = 0;
    send_frame(8'hA5, 1'b1, 16);
    idle(4);
    check("a5_valid_pulse_len", 32'(valid_cycles), 32'd1);
    check("a5_busy_after", 32'(busy), 32'd0);
    check("a5_frame_err", 32'(frame_err), 32'd0);
    check("a5_overrun", 32'(overrun), 32'd0);
    check("a5_rx_data_hold", 32'(rx_data), 32'hA5);

    // 4-cycle low glitch: rejected at the start-bit centre.
    valid_cycles = 0;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(4);
    check("glitch_busy_in_start", 32'(busy), 32'd1);
    idle(5);
    check("glitch_back_idle", 32'(busy), 32'd0);
    idle(20);
    check("glitch_no_valid", 32'(valid_cycles), 32'd0);
    check("glitch_no_ferr", 32'(frame_err), 32'd0);

    // 0x3C with a low stop bit and a 40-cycle low line.
    valid_cycles = 0;
    send_frame(8'h3C, 1'b0, 40);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_busy_in_brk", 32'(busy), 32'd1);
    check("ferr_no_valid", 32'(valid_cycles), 32'd0);
    idle(6);
    check("ferr_brk_exit", 32'(busy), 32'd0);
    idle(16);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 16);
    idle(4);
    check("ferr_sticky", 32'(frame_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ferr_cleared", 32'(frame_err), 32'd0);

    // Overrun: two frames while the consumer stalls.
    rx_ready = 1'b0;
    exp_q.push_back(8'h02);
    send_frame(8'h01, 1'b1, 16);
    send_frame(8'h02, 1'b1, 16);
    idle(4);
    check("ovr_rx_valid", 32'(rx_valid), 32'd1);
    check("ovr_rx_data", 32'(rx_data), 32'h02);
    check("ovr_set", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_valid_kept", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    idle(2);
    check("ovr_valid_dropped", 32'(rx_valid), 32'd0);

    // rx_en dropped during data bit 3 of 0xFF.
    valid_cycles = 0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    idle(8);
    rx_en = 1'b0;
    @(negedge clk);
    check("en_abort_busy", 32'(busy), 32'd0);
    idle(16);
    check("en_abort_no_valid", 32'(valid_cycles), 32'd0);
    rx_en = 1'b1;
    idle(4);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 16);
    idle(4);
    check("en_rx_data_55", 32'(rx_data), 32'h55);

    // Reset pulse during data bit 5 of a 0x6B frame.
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(d6b[i]);
    rx = d6b[5];
    idle(8);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rst_n = 1'b1;
    rx = 1'b1;
    idle(32);
    check("midrst_stays_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1, 16);
    idle(4);
    check("post_rst_rx_data", 32'(rx_data), 32'h80);
    check("post_rst_ferr", 32'(frame_err), 32'd0);
    check("post_rst_overrun", 32'(overrun), 32'd0);

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (range 5..9).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop count on rx (minimum 2).
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 rx  input  1  asynchronous serial line; idle high; LSB first.
REQ-007 rx_en  input  1  receiver enable; low forces IDLE.
REQ-008 center_tick  input  1  one-cycle pulse from phase_counter at the bit centre.
REQ-009 phase_arm  output  1  holds phase_counter at zero while high.
REQ-010 rx_data  output  DATA_BITS  last received byte; valid while rx_valid=1.
REQ-011 rx_valid  output  1  byte available.
REQ-012 rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready.
REQ-013 frame_err  output  1  sticky: stop bit sampled low.
REQ-014 overrun  output  1  sticky: byte arrived while previous one unaccepted.
REQ-015 err_clr  input  1  one-cycle pulse that clears frame_err and overrun.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 rx SHALL pass through SYNC_STAGES flops (reset value 1) before use; rx_s = last stage.
REQ-018 States: IDLE, START, DATA, STOP, BRK; encoding is free.
REQ-019 phase_arm SHALL equal 1 in IDLE and BRK and 0 in START, DATA and STOP (registered, same cycle as state).
REQ-020 IDLE: if rx_en=1 and rx_s=0 -> START; otherwise remain.
REQ-021 START, on center_tick: rx_s=1 -> IDLE (false start, no flags); rx_s=0 -> DATA with bit_cnt=0.
REQ-022 DATA, on center_tick: shift reg <= {rx_s, shift[DATA_BITS-1:1]}; bit_cnt++; after the DATA_BITS-th sample -> STOP.
REQ-023 STOP, on center_tick with rx_s=1: rx_data <= shift, rx_valid <= 1 in the next cycle, -> IDLE.
REQ-024 STOP, on center_tick with rx_s=0: frame_err <= 1, rx_data/rx_valid unchanged, -> BRK.
REQ-025 BRK: remain until rx_s=1, then -> IDLE.
REQ-026 center_tick SHALL be ignored in IDLE and BRK.
REQ-027 rx_valid SHALL clear the cycle after rx_valid & rx_ready, unless a new byte loads in that same cycle, in which case it remains 1 with the new data and overrun is not set.
REQ-028 A new byte loading while rx_valid=1 and rx_ready=0 SHALL overwrite rx_data, keep rx_valid=1 and set overrun.
REQ-029 err_clr SHALL clear both sticky flags; an error event in the same cycle as err_clr SHALL win (flag ends at 1).
REQ-030 rx_en deasserted in any state SHALL go to IDLE next cycle, discard the partial frame, and leave rx_data, rx_valid and the flags unchanged.
REQ-031 bit_cnt width SHALL be clog2(DATA_BITS+1); it SHALL never wrap past DATA_BITS.

Reset
REQ-032 rst_n=0 at a clk edge SHALL set: state IDLE, phase_arm=1, rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0, sync flops=1, shift=0, bit_cnt=0.
REQ-033 Reset mid-frame SHALL abort the frame with no output and no flags.

Verification (bench: phase_counter OVERSAMPLE=16, baud_en every cycle, DATA_BITS=8)
REQ-034 Send 0xA5 with a valid stop bit, rx_ready=1 -> rx_data=0xA5, rx_valid high for exactly 1 cycle, no flags set, busy drops after the stop-bit centre.
REQ-035 Low glitch of 4 cycles on idle rx -> returns to IDLE at the start-centre sample; no rx_valid, no flags.
REQ-036 Send 0x3C with stop bit=0, line held low for 40 cycles, then high -> frame_err=1, rx_valid=0, stays in BRK until high; then 0x11 is received correctly and frame_err stays 1 until err_clr.
REQ-037 rx_ready=0; send 0x01 then 0x02 -> rx_data=0x02, rx_valid=1, overrun=1; err_clr -> overrun=0.
REQ-038 rx_en=0 during data bit 3 of 0xFF -> busy=0 next cycle, rx_valid stays 0; re-enable, send 0x55 -> rx_data=0x55.
REQ-039 rst_n=0 for 1 cycle during data bit 5 -> all outputs take their REQ-032 values; the next frame 0x80 is received correctly.
